// File: rtl/lsu_pkg.sv
// Shared types, size codes and request legality check for the data-memory load/store unit.
// Optional: define LSU_MISALIGN_TRAP_EN to reject misaligned half/word accesses.
package lsu_pkg;

  localparam int unsigned LSU_AW = 32;
  localparam int unsigned LSU_DW = 32;

  localparam logic [1:0] SZ_B   = 2'd0;
  localparam logic [1:0] SZ_H   = 2'd1;
  localparam logic [1:0] SZ_W   = 2'd2;
  localparam logic [1:0] SZ_RSV = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } lsu_state_e;

  // Request fields held for the lifetime of one access (address lives in the mem_addr register)
  typedef struct packed {
    logic              write;
    logic [1:0]        size;
    logic              sext;
    logic [LSU_DW-1:0] wdata;
  } lsu_req_t;

  function automatic logic lsu_legal(input logic [1:0] size,
                                     input logic [LSU_AW-1:0] addr,
                                     input int unsigned mem_bytes);
    logic ok;
    ok = (size != SZ_RSV) && (addr <= LSU_AW'(mem_bytes - 32'd4));
`ifdef LSU_MISALIGN_TRAP_EN
    if (size == SZ_H && addr[0]) ok = 1'b0;
    if (size == SZ_W && addr[1:0] != 2'b00) ok = 1'b0;
`endif
    return ok;
  endfunction

endpackage

// File: rtl/dm_load_store_unit_if.sv
// CPU request/response and data-memory port bundle of the load/store unit.
interface dm_load_store_unit_if;
  import lsu_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [LSU_AW-1:0] req_addr;
  logic [LSU_DW-1:0] req_wdata;
  logic              rsp_valid;
  logic [LSU_DW-1:0] rsp_rdata;
  logic              rsp_err;
  logic [LSU_AW-1:0] mem_addr;
  logic [LSU_DW-1:0] mem_wdata;
  logic              mem_write;
  logic [LSU_DW-1:0] mem_rdata;

  // master: the CPU pipeline plus the DM array around the unit
  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_write
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_write
  );

endinterface

// File: rtl/lsu_lane_mux.sv
// Big-endian lane handling: extract+extend the addressed byte/half for loads, merge new data for sub-word stores.
module lsu_lane_mux
  import lsu_pkg::*;
(
  input  logic [1:0]        i_size,
  input  logic              i_sext,
  input  logic [LSU_DW-1:0] i_rdata,
  input  logic [LSU_DW-1:0] i_wdata,
  output logic [LSU_DW-1:0] o_load_c,
  output logic [LSU_DW-1:0] o_merge_c
);

  logic w_fill_b;
  logic w_fill_h;

  assign w_fill_b = i_sext & i_rdata[31];
  assign w_fill_h = i_sext & i_rdata[31];

  always_comb begin
    o_load_c  = i_rdata;
    o_merge_c = i_wdata;
    unique case (i_size)
      SZ_B: begin
        o_load_c  = {{24{w_fill_b}}, i_rdata[31:24]};
        o_merge_c = {i_wdata[7:0], i_rdata[23:0]};
      end
      SZ_H: begin
        o_load_c  = {{16{w_fill_h}}, i_rdata[31:16]};
        o_merge_c = {i_wdata[15:0], i_rdata[15:0]};
      end
      default: begin
        o_load_c  = i_rdata;
        o_merge_c = i_wdata;
      end
    endcase
  end

endmodule

// File: rtl/dm_load_store_unit.sv
// Data-memory load/store initiator: one request at a time, sub-word stores as read-modify-write.
// Optional: LSU_MISALIGN_TRAP_EN turns misaligned half/word requests into error responses.
module dm_load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  dm_load_store_unit_if.slave  lsu_bus
);

  lsu_state_e        r_state;
  lsu_req_t          r_req;
  logic              r_req_ready;
  logic              r_rsp_valid;
  logic [LSU_DW-1:0] r_rsp_rdata;
  logic              r_rsp_err;
  logic [LSU_AW-1:0] r_mem_addr;
  logic [LSU_DW-1:0] r_mem_wdata;
  logic              r_mem_write;

  logic [LSU_DW-1:0] w_load;
  logic [LSU_DW-1:0] w_merge;
  logic              w_legal;

  assign w_legal = lsu_legal(lsu_bus.req_size, lsu_bus.req_addr, MEM_BYTES);

  lsu_lane_mux u_lane_mux (
    .i_size    (r_req.size),
    .i_sext    (r_req.sext),
    .i_rdata   (lsu_bus.mem_rdata),
    .i_wdata   (r_req.wdata),
    .o_load_c  (w_load),
    .o_merge_c (w_merge)
  );

  // Control FSM; every output is a register updated alongside the state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_req       <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_write <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_mem_write <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (lsu_bus.req_valid && r_req_ready) begin
            r_req       <= '{write: lsu_bus.req_write, size: lsu_bus.req_size,
                             sext: lsu_bus.req_signed, wdata: lsu_bus.req_wdata};
            r_mem_addr  <= lsu_bus.req_addr;
            r_req_ready <= 1'b0;
            if (!w_legal) begin
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= '0;
            end else if (lsu_bus.req_write && lsu_bus.req_size == SZ_W) begin
              r_state     <= WRITE;
              r_mem_write <= 1'b1;
              r_mem_wdata <= lsu_bus.req_wdata;
            end else begin
              r_state <= READ;
            end
          end
        end
        READ: begin
          // Same edge serves load capture and the old-word capture of a sub-word store
          if (r_req.write) begin
            r_state     <= WRITE;
            r_mem_write <= 1'b1;
            r_mem_wdata <= w_merge;
          end else begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= w_load;
          end
        end
        WRITE: begin
          r_state     <= RESP;
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= 1'b0;
          r_rsp_rdata <= '0;
        end
        RESP: begin
          r_state     <= IDLE;
          r_req_ready <= 1'b1;
        end
        default: begin
          r_state     <= IDLE;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign lsu_bus.req_ready = r_req_ready;
  assign lsu_bus.rsp_valid = r_rsp_valid;
  assign lsu_bus.rsp_rdata = r_rsp_rdata;
  assign lsu_bus.rsp_err   = r_rsp_err;
  assign lsu_bus.mem_addr  = r_mem_addr;
  assign lsu_bus.mem_wdata = r_mem_wdata;
  assign lsu_bus.mem_write = r_mem_write;

endmodule

// File: tb/tb_dm_load_store_unit.sv
// Bench for dm_load_store_unit: directed scenarios plus random requests against a byte-array reference model.
module tb_dm_load_store_unit;

  localparam int MEM = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic dm_clear = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] dm      [MEM];
  logic [7:0] ref_mem [MEM];

  dm_load_store_unit_if bus ();

  dm_load_store_unit #(.MEM_BYTES(MEM)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .lsu_bus (bus)
  );

  always #5 clk = ~clk;

  // Big-endian DM: combinational read of addr..addr+3, write on negedge
  always_comb begin
    bus.mem_rdata = '0;
    for (int i = 0; i < 4; i++)
      if (bus.mem_addr + 32'(i) < 32'(MEM))
        bus.mem_rdata[8*(3-i) +: 8] = dm[5'(bus.mem_addr + 32'(i))];
  end

  always @(negedge clk) begin
    if (dm_clear) begin
      for (int i = 0; i < MEM; i++) dm[i] <= 8'h00;
    end else if (bus.mem_write) begin
      for (int i = 0; i < 4; i++)
        if (bus.mem_addr + 32'(i) < 32'(MEM))
          dm[5'(bus.mem_addr + 32'(i))] <= 8'(bus.mem_wdata >> (8*(3-i)));
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit model_err(input logic [1:0] sz, input logic [31:0] addr);
    bit e;
    e = (sz == 2'd3) || (addr > 32'(MEM - 4));
`ifdef LSU_MISALIGN_TRAP_EN
    if (sz == 2'd1 && (addr % 2) != 0) e = 1'b1;
    if (sz == 2'd2 && (addr % 4) != 0) e = 1'b1;
`endif
    return e;
  endfunction

  // Value of nb big-endian bytes starting at addr, extended to 32 bits
  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sx, input logic [31:0] addr);
    longint v;
    int nb;
    nb = nbytes(sz);
    v = 0;
    for (int i = 0; i < nb; i++) v = v * 256 + longint'(ref_mem[int'(addr) + i]);
    if (sx && nb < 4 && v >= (longint'(1) << (8*nb - 1))) v = v - (longint'(1) << (8*nb));
    return 32'(v);
  endfunction

  function automatic int mem_mismatches();
    int n;
    n = 0;
    for (int i = 0; i < MEM; i++) if (dm[i] !== ref_mem[i]) n++;
    return n;
  endfunction

  // Call just after a negedge with the unit idle; returns just after a negedge with the unit idle again
  task automatic do_op(input logic wr, input logic [1:0] sz, input logic sx,
                       input logic [31:0] addr, input logic [31:0] wd, input string tag);
    bit          err;
    int          lat_exp, wr_at_exp, n, wr_cnt, wr_at, nb;
    logic [31:0] exp_rd;
    err = model_err(sz, addr);
    nb  = nbytes(sz);
    if (err)                   lat_exp = 1;
    else if (!wr)              lat_exp = 2;
    else if (sz == 2'd2)       lat_exp = 2;
    else                       lat_exp = 3;
    exp_rd    = (err || wr) ? 32'h0 : model_load(sz, sx, addr);
    wr_at_exp = (wr && !err) ? lat_exp - 1 : 0;

    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_size   = sz;
    bus.req_signed = sx;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    check({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    n = 0; wr_cnt = 0; wr_at = 0;
    do begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      n++;
      if (bus.mem_write) begin wr_cnt++; wr_at = n; end
    end while (!bus.rsp_valid && n < 8);
    check({tag, "_lat"},    32'(n),           32'(lat_exp));
    check({tag, "_err"},    32'(bus.rsp_err), 32'(err));
    check({tag, "_rdata"},  bus.rsp_rdata,    exp_rd);
    check({tag, "_wrcnt"},  32'(wr_cnt),      32'((wr && !err) ? 1 : 0));
    check({tag, "_wrat"},   32'(wr_at),       32'(wr_at_exp));
    if (wr && !err)
      for (int i = 0; i < nb; i++) ref_mem[int'(addr) + i] = 8'(wd >> (8*(nb-1-i)));
    @(negedge clk);
    check({tag, "_pulse"},  32'(bus.rsp_valid), 32'd0);
    check({tag, "_idle"},   32'(bus.req_ready), 32'd1);
    check({tag, "_hold"},   bus.rsp_rdata,      exp_rd);
    check({tag, "_mem"},    32'(mem_mismatches()), 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'd0;
    bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    for (int i = 0; i < MEM; i++) ref_mem[i] = 8'h00;

    #2 rst = 1'b1;
    dm_clear = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ready",  32'(bus.req_ready), 32'd1);
    check("rst_valid",  32'(bus.rsp_valid), 32'd0);
    check("rst_rdata",  bus.rsp_rdata,      32'd0);
    check("rst_err",    32'(bus.rsp_err),   32'd0);
    check("rst_maddr",  bus.mem_addr,       32'd0);
    check("rst_mwdata", bus.mem_wdata,      32'd0);
    check("rst_mwrite", 32'(bus.mem_write), 32'd0);
    rst = 1'b0;
    dm_clear = 1'b0;

    // Byte loads with both extensions
    do_op(1'b1, 2'd2, 1'b0, 32'd4, 32'h8012_3456, "t1_pre");
    do_op(1'b0, 2'd0, 1'b1, 32'd4, 32'h0, "t1_lbs");
    check("t1_lbs_const", bus.rsp_rdata, 32'hFFFF_FF80);
    do_op(1'b0, 2'd0, 1'b0, 32'd4, 32'h0, "t1_lbu");
    check("t1_lbu_const", bus.rsp_rdata, 32'h0000_0080);

    // Word store
    do_op(1'b1, 2'd2, 1'b0, 32'd8, 32'hDEAD_BEEF, "t2_sw");
    check("t2_mem_const", {dm[8], dm[9], dm[10], dm[11]}, 32'hDEAD_BEEF);

    // Half store as read-modify-write
    do_op(1'b1, 2'd2, 1'b0, 32'd12, 32'h1122_3344, "t3_pre");
    do_op(1'b1, 2'd1, 1'b0, 32'd12, 32'h0000_ABCD, "t3_sh");
    check("t3_mem_const", {dm[12], dm[13], dm[14], dm[15]}, 32'hABCD_3344);
    do_op(1'b0, 2'd1, 1'b1, 32'd14, 32'h0, "t3_lhs");

    // Range and reserved-size errors, last legal address
    do_op(1'b0, 2'd2, 1'b0, 32'd29, 32'h0, "t4_range");
    do_op(1'b1, 2'd2, 1'b0, 32'd29, 32'h1234_5678, "t4_srange");
    do_op(1'b0, 2'd3, 1'b0, 32'd0,  32'h0, "t4_size3");
    do_op(1'b1, 2'd2, 1'b0, 32'd28, 32'hCAFE_F00D, "t4_last");

    // Misaligned word load
    do_op(1'b0, 2'd2, 1'b0, 32'd2, 32'h0, "t5_mis");
`ifdef LSU_MISALIGN_TRAP_EN
    check("t5_err_const", 32'(bus.rsp_err), 32'd1);
`else
    check("t5_data_const", bus.rsp_rdata, 32'h0000_8012);
`endif

    // Reset inside WRITE before the committing negedge
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'd1;
    bus.req_signed = 1'b0; bus.req_addr = 32'd12; bus.req_wdata = 32'h0000_5555;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("t6_inwrite", 32'(bus.mem_write), 32'd1);
    rst = 1'b1;
    #1;
    check("t6_ready",  32'(bus.req_ready), 32'd1);
    check("t6_mwrite", 32'(bus.mem_write), 32'd0);
    check("t6_valid",  32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op(1'b0, 2'd2, 1'b0, 32'd12, 32'h0, "t6_after");
    check("t6_mem_const", bus.rsp_rdata, 32'hABCD_3344);

    // Random traffic
    for (int k = 0; k < 80; k++) begin
      a = ($urandom_range(0, 7) == 0) ? 32'h100 + 32'($urandom_range(0, 255))
                                       : 32'($urandom_range(0, MEM - 1));
      do_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            a, $urandom, $sformatf("rnd%0d", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
